stepdown_corestate_seq: RTL and testbench
=========================================

# stepdown_corestate_seq

Clocked sequencer that generates the `Tstate` core-state enable consumed by the step-down input gating cells, where each gated input is passed as `o = i0 & Tstate`. It sequences the step-down core through arm, soft-start ramp, run and drain phases. It also runs a four-phase req/ack handshake with the power-control master and latches fault conditions. It sits between the power-control master and the gated input cells of the step-down core.

## Interface
Parameters:
- BLANK_CYCLES, 8, arm and drain blanking duration in clk cycles (≥1)
- SS_CYCLES, 64, soft-start ramp duration in clk cycles (≥1)
- SYNC_STAGES, 2, flops in the pgood synchronizer (≥2)

Ports:
- clk  input  1  sequencer clock
- rst_n  input  1  asynchronous active-low reset
- req  input  1  core-on request from the master, level, synchronous to clk
- pgood  input  1  power-good from the analog core, asynchronous, synchronized internally
- fault_in  input  1  external fault, synchronous, active high
- fault_clr  input  1  fault clear, synchronous, active high
- Tstate  output  1  core-state enable to the gating cells, registered
- ack  output  1  handshake acknowledge, registered
- state  output  3  current state code
- fault_code  output  2  latched fault cause
- CELV, CELG, SUB  input  1 each  supply, ground and substrate pass-through connections; no logic

## Operation
- State codes: IDLE=0, ARM=1, RAMP=2, RUN=3, DRAIN=4, FAULT=5. Codes 6 and 7 are illegal and return to IDLE on the next edge.
- One shared counter of width $clog2(max(BLANK_CYCLES,SS_CYCLES)+1). It clears on every state entry.
- IDLE: Tstate=0, ack=0. req=1 moves to ARM.
- ARM: after BLANK_CYCLES cycles in ARM, move to RAMP.
- RAMP: after SS_CYCLES cycles, move to RUN if pgood_s=1. If pgood_s=0 at that point, move to FAULT with fault_code=2 (ramp timeout).
- RUN: Tstate=1, ack=1. req=0 moves to DRAIN. pgood_s=0 moves to FAULT with fault_code=3.
- DRAIN: Tstate=0, ack=1. After BLANK_CYCLES cycles, move to IDLE, where ack falls.
- req=0 while in ARM or RAMP aborts the sequence to DRAIN.
- FAULT: Tstate=0, ack=0, fault_code held. fault_clr=1 together with req=0 moves to IDLE and clears fault_code to 0. fault_clr with req=1 is ignored.
- fault_in=1 in any state other than IDLE or FAULT moves to FAULT with fault_code=1.
- Transition priority: fault_in > pgood loss / ramp timeout > req drop > counter terminal.
- pgood_s is pgood passed through SYNC_STAGES flops, all of which reset to 0.

## Timing
- Reset, asynchronous on rst_n low:
  - state=IDLE, Tstate=0, ack=0, fault_code=0, counter=0, sync flops=0.
  - Takes effect immediately, including mid-sequence.
- Tstate and ack are decoded from the next state and registered. Both update on the same edge as the state change, so there is no extra cycle of lag.
- Latency: let E0 be the first edge that samples req=1 in IDLE.
  - ARM from E0.
  - RAMP from E0+BLANK_CYCLES.
  - RUN, with Tstate=1 and ack=1, from E0+BLANK_CYCLES+SS_CYCLES. This is edge E0+72 at default parameters.
- pgood must rise at least SYNC_STAGES edges before the RAMP terminal edge to be seen in time.
- Drain: Tstate falls on the edge that samples req=0 in RUN. ack falls BLANK_CYCLES edges later.
- Handshake rules:
  - The master holds req high until ack=1.
  - The master holds req low until ack=0.
  - A new request is accepted only in IDLE.
- fault_in sampled at edge E gives Tstate=0 after E. The FAULT exit to IDLE takes one edge.

## Test plan
- Reset, then req=1 with pgood rising 10 cycles later (defaults) → state sequence 1→2→3. Tstate=1 and ack=1 exactly 72 edges after the first edge sampling req=1.
- From RUN, drop req → Tstate=0 on the next edge, state=4, ack=0 and state=0 eight edges later.
- Keep pgood=0 throughout the ramp → FAULT at edge E0+72 with fault_code=2 and Tstate never high. fault_clr with req=1 has no effect. fault_clr with req=0 returns to IDLE with fault_code=0.
- In RUN, pulse pgood low for 3 cycles → FAULT with fault_code=3 after the synchronizer delay (2 edges plus 1). In RAMP, assert fault_in and drop req on the same edge → FAULT with fault_code=1, showing fault priority.
- Drop req at ARM cycle 3 → DRAIN, Tstate never asserted, back in IDLE 8 edges later. Assert rst_n=0 in RUN between clock edges → Tstate and ack go to 0 immediately.
- Force state code 6 → IDLE on the next edge. Run with BLANK_CYCLES=1 and SS_CYCLES=1 → RUN 2 edges after E0.

Source files
------------

// File: rtl/stepdown_corestate_seq.sv
// Core-state sequencer for the step-down input gating cells: arm, soft-start ramp, run, drain,
// with a four-phase req/ack handshake to the power-control master and latched fault causes.
module stepdown_corestate_seq #(
    parameter int unsigned BLANK_CYCLES = 8,
    parameter int unsigned SS_CYCLES    = 64,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       pgood,
    input  logic       fault_in,
    input  logic       fault_clr,
    input  logic       CELV,
    input  logic       CELG,
    input  logic       SUB,
    output logic       Tstate,
    output logic       ack,
    output logic [2:0] state,
    output logic [1:0] fault_code
);

    localparam int unsigned MaxCycles = (BLANK_CYCLES > SS_CYCLES) ? BLANK_CYCLES : SS_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArm   = 3'd1,
        StRamp  = 3'd2,
        StRun   = 3'd3,
        StDrain = 3'd4,
        StFault = 3'd5
    } state_e;

    localparam logic [1:0] FaultNone   = 2'd0;
    localparam logic [1:0] FaultExt    = 2'd1;
    localparam logic [1:0] FaultRampTo = 2'd2;
    localparam logic [1:0] FaultPgood  = 2'd3;

    // Kept as a plain vector so the unused codes 6 and 7 remain representable.
    logic [2:0]            state_q, state_d;
    logic [1:0]            fault_code_q, fault_code_d;
    logic [CntW-1:0]       cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  tstate_q, ack_q;
    logic                  pgood_s;
    logic                  blank_done, ss_done;

    // Supply, ground and substrate only pass through this block.
    logic unused_pins;
    assign unused_pins = ^{CELV, CELG, SUB};

    assign pgood_s    = sync_q[SYNC_STAGES-1];
    assign blank_done = (cnt_q == CntW'(BLANK_CYCLES - 1));
    assign ss_done    = (cnt_q == CntW'(SS_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pgood};
        end
    end

    // Priority inside each state: fault_in, then pgood loss / ramp timeout, then req drop,
    // then counter terminal.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        case (state_q)
            StIdle: begin
                if (req) state_d = StArm;
            end
            StArm: begin
                if (fault_in) begin
                    state_d      = StFault;
                    fault_code_d = FaultExt;
                end else if (!req) begin
                    state_d = StDrain;
                end else if (blank_done) begin
                    state_d = StRamp;
                end
            end
            StRamp: begin
                if (fault_in) begin
                    state_d      = StFault;
                    fault_code_d = FaultExt;
                end else if (ss_done && !pgood_s) begin
                    state_d      = StFault;
                    fault_code_d = FaultRampTo;
                end else if (!req) begin
                    state_d = StDrain;
                end else if (ss_done) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (fault_in) begin
                    state_d      = StFault;
                    fault_code_d = FaultExt;
                end else if (!pgood_s) begin
                    state_d      = StFault;
                    fault_code_d = FaultPgood;
                end else if (!req) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fault_in) begin
                    state_d      = StFault;
                    fault_code_d = FaultExt;
                end else if (blank_done) begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                if (fault_clr && !req) begin
                    state_d      = StIdle;
                    fault_code_d = FaultNone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fault_code_q <= FaultNone;
            cnt_q        <= '0;
            tstate_q     <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == StArm || state_q == StRamp || state_q == StDrain) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            tstate_q <= (state_d == StRun);
            ack_q    <= (state_d == StRun) || (state_d == StDrain);
        end
    end

    assign Tstate     = tstate_q;
    assign ack        = ack_q;
    assign state      = state_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_stepdown_corestate_seq.sv
// Directed bench for stepdown_corestate_seq: default instance plus a BLANK=1/SS=1 instance.
module tb_stepdown_corestate_seq;

    logic       clk;
    logic       rst_n;
    logic       req, pgood, fault_in, fault_clr;
    logic       tstate, ack;
    logic [2:0] state;
    logic [1:0] fault_code;

    logic       f_req;
    logic       f_pgood;
    logic       f_tstate, f_ack;
    logic [2:0] f_state;
    logic [1:0] f_fault_code;

    int n_total = 0;
    int n_bad   = 0;
    logic seen;

    stepdown_corestate_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .pgood      (pgood),
        .fault_in   (fault_in),
        .fault_clr  (fault_clr),
        .CELV       (1'b1),
        .CELG       (1'b0),
        .SUB        (1'b0),
        .Tstate     (tstate),
        .ack        (ack),
        .state      (state),
        .fault_code (fault_code)
    );

    stepdown_corestate_seq #(
        .BLANK_CYCLES (1),
        .SS_CYCLES    (1),
        .SYNC_STAGES  (2)
    ) dut_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (f_req),
        .pgood      (f_pgood),
        .fault_in   (1'b0),
        .fault_clr  (1'b0),
        .CELV       (1'b1),
        .CELG       (1'b0),
        .SUB        (1'b0),
        .Tstate     (f_tstate),
        .ack        (f_ack),
        .state      (f_state),
        .fault_code (f_fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        pgood     = 1'b0;
        fault_in  = 1'b0;
        fault_clr = 1'b0;
        f_req     = 1'b0;
        f_pgood   = 1'b1;

        step(3);
        check("rst_state", {5'b0, state}, 8'd0);
        check("rst_tstate", {7'b0, tstate}, 8'd0);
        check("rst_ack", {7'b0, ack}, 8'd0);
        check("rst_fcode", {6'b0, fault_code}, 8'd0);
        rst_n = 1'b1;
        step(2);

        // Normal power-up: pgood rises 10 cycles after E0, RUN at E0+72.
        req = 1'b1;
        step(1);
        check("e0_arm", {5'b0, state}, 8'd1);
        seen = 1'b0;
        for (int k = 1; k <= 71; k++) begin
            step(1);
            seen |= tstate;
            if (k == 10) pgood = 1'b1;
            if (k == 7) check("arm_last", {5'b0, state}, 8'd1);
            if (k == 8) check("ramp_entry", {5'b0, state}, 8'd2);
        end
        check("ramp_before_run", {5'b0, state}, 8'd2);
        check("no_early_tstate", {7'b0, seen}, 8'd0);
        step(1);
        check("run_state", {5'b0, state}, 8'd3);
        check("run_tstate", {7'b0, tstate}, 8'd1);
        check("run_ack", {7'b0, ack}, 8'd1);

        // Drain after req drop.
        req = 1'b0;
        step(1);
        check("drain_state", {5'b0, state}, 8'd4);
        check("drain_tstate", {7'b0, tstate}, 8'd0);
        check("drain_ack", {7'b0, ack}, 8'd1);
        step(7);
        check("drain_hold", {5'b0, state}, 8'd4);
        check("drain_hold_ack", {7'b0, ack}, 8'd1);
        step(1);
        check("drain_idle", {5'b0, state}, 8'd0);
        check("drain_ack_low", {7'b0, ack}, 8'd0);

        // fault_in is ignored in IDLE.
        fault_in = 1'b1;
        step(1);
        fault_in = 1'b0;
        check("idle_fault_ign", {5'b0, state}, 8'd0);

        // Ramp timeout with pgood low throughout.
        pgood = 1'b0;
        step(3);
        req = 1'b1;
        step(1);
        seen = 1'b0;
        for (int k = 1; k <= 71; k++) begin
            step(1);
            seen |= tstate;
        end
        check("to_ramp", {5'b0, state}, 8'd2);
        step(1);
        seen |= tstate;
        check("to_fault", {5'b0, state}, 8'd5);
        check("to_fcode", {6'b0, fault_code}, 8'd2);
        check("to_never_tstate", {7'b0, seen}, 8'd0);
        check("to_ack", {7'b0, ack}, 8'd0);
        fault_clr = 1'b1;
        step(1);
        check("clr_req_hi_state", {5'b0, state}, 8'd5);
        check("clr_req_hi_fcode", {6'b0, fault_code}, 8'd2);
        req = 1'b0;
        step(1);
        fault_clr = 1'b0;
        check("clr_state", {5'b0, state}, 8'd0);
        check("clr_fcode", {6'b0, fault_code}, 8'd0);

        // pgood glitch in RUN.
        pgood = 1'b1;
        step(3);
        req = 1'b1;
        step(73);
        check("run2_state", {5'b0, state}, 8'd3);
        pgood = 1'b0;
        step(2);
        check("glitch_still_run", {5'b0, state}, 8'd3);
        step(1);
        pgood = 1'b1;
        check("glitch_fault", {5'b0, state}, 8'd5);
        check("glitch_fcode", {6'b0, fault_code}, 8'd3);
        check("glitch_tstate", {7'b0, tstate}, 8'd0);
        req = 1'b0;
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check("glitch_clr", {5'b0, state}, 8'd0);

        // fault_in beats req drop in RAMP.
        step(3);
        req = 1'b1;
        step(9);
        check("ramp3_state", {5'b0, state}, 8'd2);
        fault_in = 1'b1;
        req = 1'b0;
        step(1);
        fault_in = 1'b0;
        check("prio_state", {5'b0, state}, 8'd5);
        check("prio_fcode", {6'b0, fault_code}, 8'd1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check("prio_clr", {5'b0, state}, 8'd0);

        // Abort from ARM.
        req = 1'b1;
        step(3);
        check("abort_arm", {5'b0, state}, 8'd1);
        req = 1'b0;
        seen = 1'b0;
        step(1);
        seen |= tstate;
        check("abort_drain", {5'b0, state}, 8'd4);
        for (int k = 1; k <= 7; k++) begin
            step(1);
            seen |= tstate;
        end
        check("abort_drain_hold", {5'b0, state}, 8'd4);
        step(1);
        check("abort_idle", {5'b0, state}, 8'd0);
        check("abort_no_tstate", {7'b0, seen}, 8'd0);

        // Asynchronous reset mid-RUN.
        req = 1'b1;
        step(73);
        check("run3_tstate", {7'b0, tstate}, 8'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_tstate", {7'b0, tstate}, 8'd0);
        check("async_ack", {7'b0, ack}, 8'd0);
        check("async_state", {5'b0, state}, 8'd0);
        req = 1'b0;
        step(1);
        rst_n = 1'b1;
        pgood = 1'b1;
        step(3);

        // Illegal code 6 recovers to IDLE.
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        step(1);
        check("illegal_idle", {5'b0, state}, 8'd0);

        // Minimum blanking and ramp: RUN two edges after E0.
        f_req = 1'b1;
        step(1);
        check("fast_arm", {5'b0, f_state}, 8'd1);
        step(1);
        check("fast_ramp", {5'b0, f_state}, 8'd2);
        step(1);
        check("fast_run", {5'b0, f_state}, 8'd3);
        check("fast_tstate", {7'b0, f_tstate}, 8'd1);
        check("fast_ack", {7'b0, f_ack}, 8'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
